cv32e40x_bit_iter: RTL and testbench

Sequential set-bit enumerator. Accepts an LEN-bit vector and returns the index of each set bit, one per valid/ready beat, in ascending or descending order. Each emitted bit is cleared until the vector is exhausted. Serves multi-cycle sequencers that walk a bit list, such as register-list push/pop and pending-source scans, behind a registered pending mask and a single-cycle priority search.

---
 rtl/cv32e40x_bit_iter_pkg.sv | 9 +
 rtl/cv32e40x_ff_one_dir.sv | 42 ++++
 rtl/cv32e40x_bit_iter.sv | 136 +++++++++++++
 tb/tb_cv32e40x_bit_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_bit_iter_pkg.sv
// Shared types for the set-bit enumerator.
package cv32e40x_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } bit_iter_state_e;

endpackage

// File: rtl/cv32e40x_ff_one_dir.sv
// Combinational first-set-bit search in either direction over a balanced binary tree.
module cv32e40x_ff_one_dir #(
  parameter int   LEN = 32,
  localparam int  IW  = $clog2(LEN)
) (
  input  logic [LEN-1:0] vec,
  input  logic           desc,
  output logic [IW-1:0]  first_idx,
  output logic           no_ones
);

  localparam int            NPOW    = 1 << IW;
  localparam logic [IW-1:0] MAX_IDX = IW'(LEN - 1);

  // Level 0 holds the leaves; each following level halves the node count.
  // Left child is always the lower position, so preferring it yields the lowest set bit.
  for (genvar gi = 0; gi <= IW; gi++) begin : gen_lvl
    localparam int N = NPOW >> gi;
    logic [N-1:0]  v;
    logic [IW-1:0] ix [N];

    for (genvar gj = 0; gj < N; gj++) begin : gen_node
      if (gi == 0) begin : gen_leaf
        if (gj < LEN) begin : gen_used
          // Descending search reuses the ascending tree on the bit-reversed vector.
          assign v[gj] = desc ? vec[LEN-1-gj] : vec[gj];
        end else begin : gen_pad
          assign v[gj] = 1'b0;
        end
        assign ix[gj] = IW'(gj);
      end else begin : gen_inner
        assign v[gj]  = gen_lvl[gi-1].v[2*gj] | gen_lvl[gi-1].v[2*gj+1];
        assign ix[gj] = gen_lvl[gi-1].v[2*gj] ? gen_lvl[gi-1].ix[2*gj]
                                              : gen_lvl[gi-1].ix[2*gj+1];
      end
    end
  end

  assign no_ones   = ~gen_lvl[IW].v[0];
  assign first_idx = desc ? (MAX_IDX - gen_lvl[IW].ix[0]) : gen_lvl[IW].ix[0];

endmodule

// File: rtl/cv32e40x_bit_iter.sv
// Sequential set-bit enumerator: walks a registered pending mask one index per beat.
module cv32e40x_bit_iter
  import cv32e40x_pkg::*;
#(
  parameter int   LEN = 32,
  localparam int  IW  = $clog2(LEN),
  localparam int  CW  = $clog2(LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_valid_i,
  output logic           load_ready_o,
  input  logic [LEN-1:0] load_vec_i,
  input  logic           load_desc_i,
  output logic           idx_valid_o,
  input  logic           idx_ready_i,
  output logic [IW-1:0]  idx_o,
  output logic           idx_last_o,
  input  logic           kill_i,
  output logic           busy_o,
  output logic [CW-1:0]  remaining_o,
  output logic           done_o
);

  bit_iter_state_e state_reg, state_next;
  logic [LEN-1:0]  pending_reg, pending_next;
  logic            desc_reg, desc_next;
  logic            done_reg, done_next;

  logic [IW-1:0]   ff_idx;
  logic            ff_none;
  logic [LEN-1:0]  clr_mask;
  logic [CW-1:0]   pop_cnt;
  logic            load_acc;
  logic            beat;
  logic            last_beat;

  cv32e40x_ff_one_dir #(
    .LEN (LEN)
  ) u_ff_one_dir (
    .vec       (pending_reg),
    .desc      (desc_reg),
    .first_idx (ff_idx),
    .no_ones   (ff_none)
  );

  // One-hot of the selected bit, used to retire it on a beat.
  for (genvar gi = 0; gi < LEN; gi++) begin : gen_clr
    assign clr_mask[gi] = (ff_idx == IW'(gi));
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < LEN; i++) begin
      pop_cnt = pop_cnt + CW'(pending_reg[i]);
    end
  end

  assign load_acc  = load_valid_i & load_ready_o;
  assign beat      = idx_valid_o & idx_ready_i;
  assign last_beat = beat & (pop_cnt == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      desc_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      desc_reg    <= desc_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic; kill overrides every other transition and suppresses done.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    desc_next    = desc_reg;
    done_next    = 1'b0;
    if (kill_i) begin
      state_next   = IDLE;
      pending_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (load_acc) begin
            if (load_vec_i != '0) begin
              state_next   = ITER;
              pending_next = load_vec_i;
              desc_next    = load_desc_i;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        ITER: begin
          if (beat) begin
            pending_next = pending_reg & ~clr_mask;
          end
          if (last_beat || ff_none) begin
            state_next = IDLE;
            done_next  = last_beat;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    load_ready_o = 1'b0;
    idx_valid_o  = 1'b0;
    idx_o        = '0;
    idx_last_o   = 1'b0;
    busy_o       = 1'b0;
    unique case (state_reg)
      IDLE: load_ready_o = ~kill_i;
      ITER: begin
        idx_valid_o = 1'b1;
        idx_o       = ff_idx;
        idx_last_o  = (pop_cnt == CW'(1));
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

  assign remaining_o = pop_cnt;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_cv32e40x_bit_iter.sv
// Directed plus randomized checks of the set-bit enumerator at LEN=32 and LEN=5.
module tb_cv32e40x_bit_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lv, desc, ir, kill;
  logic [31:0] vec;
  logic        load_ready, idx_valid, idx_last, busy, done;
  logic [4:0]  idx;
  logic [5:0]  remaining;

  logic        lv5, desc5, ir5, kill5;
  logic [4:0]  vec5;
  logic        load_ready5, idx_valid5, idx_last5, busy5, done5;
  logic [2:0]  idx5;
  logic [2:0]  remaining5;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  cv32e40x_bit_iter #(.LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid_i(lv), .load_ready_o(load_ready),
    .load_vec_i(vec), .load_desc_i(desc), .idx_valid_o(idx_valid), .idx_ready_i(ir),
    .idx_o(idx), .idx_last_o(idx_last), .kill_i(kill), .busy_o(busy),
    .remaining_o(remaining), .done_o(done)
  );

  cv32e40x_bit_iter #(.LEN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .load_valid_i(lv5), .load_ready_o(load_ready5),
    .load_vec_i(vec5), .load_desc_i(desc5), .idx_valid_o(idx_valid5), .idx_ready_i(ir5),
    .idx_o(idx5), .idx_last_o(idx_last5), .kill_i(kill5), .busy_o(busy5),
    .remaining_o(remaining5), .done_o(done5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of set-bit positions, ascending, reversed for descending order.
  task automatic fill_q(input logic [31:0] v, input int len, input bit d);
    exp_q.delete();
    for (int i = 0; i < len; i++) if (v[i]) exp_q.push_back(i);
    if (d) exp_q.reverse();
  endtask

  // Starts and ends on a negedge; mode 0: always ready, 1: toggling, 2: random.
  task automatic run32(input logic [31:0] v, input bit d, input int mode);
    int cyc, beats;
    logic rdy;
    chk("ready_idle", load_ready, 1);
    lv = 1; vec = v; desc = d;
    fill_q(v, 32, d);
    beats = exp_q.size();
    @(posedge clk); @(negedge clk);
    lv = 0;
    if (exp_q.size() == 0) begin
      chk("zero_done", done, 1);
      chk("zero_valid", idx_valid, 0);
      chk("zero_ready", load_ready, 1);
    end else begin
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
        chk("valid", idx_valid, 1);
        chk("idx", idx, exp_q[0]);
        chk("last", idx_last, (exp_q.size() == 1));
        chk("remaining", remaining, exp_q.size());
        chk("ready_busy", load_ready, 0);
        chk("done_early", done, 0);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = 1'($urandom % 2);
        endcase
        ir = rdy;
        @(posedge clk); @(negedge clk);
        if (rdy) void'(exp_q.pop_front());
        cyc++;
      end
      if (exp_q.size() > 0) chk("beat_timeout", exp_q.size(), 0);
      ir = 0;
      chk("done", done, 1);
      chk("valid_after", idx_valid, 0);
      chk("remaining_after", remaining, 0);
      chk("busy_after", busy, 0);
    end
    $display("txn32 vec=%08h desc=%0d mode=%0d beats=%0d", v, d, mode, beats);
  endtask

  task automatic run5(input logic [4:0] v, input bit d);
    int cyc;
    logic rdy;
    lv5 = 1; vec5 = v; desc5 = d;
    fill_q({27'd0, v}, 5, d);
    @(posedge clk); @(negedge clk);
    lv5 = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      chk("idx5_range", (idx5 < 3'd5), 1);
      chk("idx5", idx5, exp_q[0]);
      chk("last5", idx_last5, (exp_q.size() == 1));
      chk("remaining5", remaining5, exp_q.size());
      rdy = 1'($urandom % 2);
      ir5 = rdy;
      @(posedge clk); @(negedge clk);
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    if (exp_q.size() > 0) chk("beat5_timeout", exp_q.size(), 0);
    ir5 = 0;
    chk("done5", done5, 1);
    chk("busy5_after", busy5, 0);
    $display("txn5 vec=%05b desc=%0d", v, d);
  endtask

  initial begin
    rst_n = 0; lv = 0; desc = 0; ir = 0; kill = 0; vec = '0;
    lv5 = 0; desc5 = 0; ir5 = 0; kill5 = 0; vec5 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", load_ready, 1);
    chk("rst_valid", idx_valid, 0);
    chk("rst_idx", idx, 0);
    chk("rst_last", idx_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    @(negedge clk);

    run32(32'h0000_8011, 1'b0, 0);
    run32(32'h0000_8011, 1'b1, 0);
    run32(32'hFFFF_FFFF, 1'b0, 1);
    run32(32'h0000_0000, 1'b0, 0);
    run32(32'h8000_0001, 1'b1, 0);

    // Kill after the first beat of 0xF0.
    chk("ready_idle_k", load_ready, 1);
    lv = 1; vec = 32'h0000_00F0; desc = 0;
    @(posedge clk); @(negedge clk);
    lv = 0;
    chk("kill_first_idx", idx, 4);
    chk("kill_first_rem", remaining, 4);
    ir = 1; kill = 1;
    @(posedge clk); @(negedge clk);
    ir = 0; kill = 0;
    chk("kill_valid", idx_valid, 0);
    chk("kill_rem", remaining, 0);
    chk("kill_busy", busy, 0);
    chk("kill_done", done, 0);
    @(negedge clk);
    chk("kill_done_late", done, 0);
    $display("txn32 kill after first beat");

    // Kill with a simultaneous load: load refused.
    kill = 1; lv = 1; vec = 32'h0000_00FF;
    #1 chk("kill_load_ready", load_ready, 0);
    @(posedge clk); @(negedge clk);
    kill = 0; lv = 0;
    chk("kill_load_busy", busy, 0);
    chk("kill_load_rem", remaining, 0);
    chk("kill_load_done", done, 0);
    $display("txn32 kill with load");

    // Asynchronous reset mid-enumeration.
    lv = 1; vec = 32'h0000_00FF; desc = 1;
    @(posedge clk); @(negedge clk);
    lv = 0;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_idx", idx, 7);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", idx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rem", remaining, 0);
    chk("arst_idx", idx, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("arst_done_late", done, 0);
    $display("txn32 async reset mid-iteration");

    run5(5'b10001, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run32($urandom & $urandom, 1'($urandom % 2), 2);
      run5(5'($urandom), 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
